buffer_lru_cam: RTL and testbench
=================================

// Module: buffer_lru_cam
// PURPOSE
//  Parametrised successor of the LRU value buffer: fully associative store of BUF_SIZE WIDTH-bit values.
//  Supports insert, lookup and invalidate ops with true-LRU replacement.
//  Per-slot valid bits allow value 0 to be stored.
//  Each op returns a registered response: hit flag, slot index and evicted value.
//  Sits between a request producer and any consumer of the cached-value array.
// PARAMETERS
//  WIDTH        16  bit width of each stored value
//  BUF_SIZE     8   number of slots, >=2
//  LOOKUP_TOUCH 1   1: a lookup hit refreshes recency; 0: lookup is read-only
// PORTS
//  clk_i          in   1                  clock, all state on rising edge
//  rst_i          in   1                  reset, asynchronous, active-high
//  op_valid_i     in   1                  op request this cycle; ignored while rst_i=1
//  op_i           in   2                  buffer_lru_pkg::op_e: OP_INSERT / OP_LOOKUP / OP_INVALIDATE
//  val_i          in   WIDTH              operand value
//  resp_valid_o   out  1                  one-cycle pulse, cycle after an accepted op
//  hit_o          out  1                  val_i was present (valid slot matched) when the op was accepted
//  slot_o         out  IDXW               slot hit, or slot written on insert miss; 0 for lookup/invalidate miss
//  evict_valid_o  out  1                  insert overwrote a valid entry
//  evict_val_o    out  WIDTH              overwritten value; 0 when evict_valid_o=0
//  buf_array_o    out  BUF_SIZE x WIDTH   slot contents, packed [BUF_SIZE-1:0][WIDTH-1:0]
//  valid_o        out  BUF_SIZE           per-slot valid mask
//  count_o        out  IDXW+1             number of valid slots
// BEHAVIOUR
//  - IDXW = $clog2(BUF_SIZE).
//  - Recency is tracked per slot as rank[i] in 0..BUF_SIZE-1: 0 = MRU, BUF_SIZE-1 = LRU.
//    The ranks always form a permutation.
//  - Reset (async, any cycle, mid-op included) sets all outputs to 0, all slots to 0 and invalid, and rank[i]=i.
//    An op in flight is dropped and no resp_valid_o pulse follows.
//  - Every op is accepted in 1 cycle; there is no backpressure. Latency is 1:
//    - state and responses update at the edge that samples op_valid_i=1;
//    - resp_valid_o is high for the following cycle only.
//  - Match: compare val_i to every valid slot in parallel. At most one slot can match (duplicates are never created).
//  - touch(s): every slot with rank < rank[s] increments its rank; rank[s] := 0.
//  - OP_INSERT, hit: touch(slot), contents unchanged.
//  - OP_INSERT, miss, an invalid slot exists:
//    - victim = lowest-index invalid slot;
//    - write val_i, set valid, touch(victim), evict_valid_o=0.
//  - OP_INSERT, miss, buffer full:
//    - victim = slot with rank BUF_SIZE-1;
//    - evict_valid_o=1 and evict_val_o = old contents;
//    - write val_i, touch(victim). count_o is unchanged.
//  - OP_LOOKUP: no content change. On a hit, touch only if LOOKUP_TOUCH=1. A miss changes nothing.
//  - OP_INVALIDATE, hit on slot s:
//    - clear valid[s] and zero its data;
//    - slots with rank > rank[s] decrement; rank[s] := BUF_SIZE-1.
//  - OP_INVALIDATE, miss: no change, hit_o=0.
//  - An invalidated slot becomes the preferred victim again (lowest-index invalid rule).
//  - count_o saturates naturally at BUF_SIZE; it never wraps.
//  - Back-to-back ops on consecutive cycles each see the state left by the previous op.
//  - op_valid_i=0 leaves everything unchanged and resp_valid_o=0.
// STRUCTURE
//  - buffer_lru_pkg holds: typedef enum logic [1:0] op_e {OP_INSERT=0, OP_LOOKUP=1, OP_INVALIDATE=2}.
//    Value 3 is reserved and treated as NOP: accepted, resp_valid_o=1, hit_o=0, no change.
//  - Sub-module lru_rank_tracker #(BUF_SIZE) owns the rank registers. It provides:
//    - inputs: touch_en, touch_idx, drop_en, drop_idx;
//    - output: lru_idx.
//  - The top level owns data, valid, the match logic, victim priority encode and the response registers.
// TESTING
//  - Reset: pulse rst_i asynchronously between edges, including during an op.
//    -> all outputs 0 immediately; no resp_valid_o the cycle after.
//  - Fill and LRU with BUF_SIZE=8, WIDTH=16, inserting 100,101,102,103,101,104,105,106,107,108,109,110,110,111,112.
//    -> final array {108,111,109,110,112,105,106,107}.
//    -> the 101 and second 110 inserts give hit_o=1.
//    -> the insert of 108 gives evict_valid_o=1, evict_val_o=100, slot_o=0.
//  - Zero value: insert 0 into an empty buffer -> valid_o=8'h01, count_o=1; lookup 0 -> hit_o=1, slot_o=0.
//  - Invalidate and refill, starting from a full buffer {100..107}:
//    - invalidate 103 -> valid_o=8'hF7, count_o=7;
//    - insert 200 -> slot_o=3, evict_valid_o=0;
//    - insert 201 -> evicts 100.
//  - LOOKUP_TOUCH, starting from a full buffer {100..107}, lookup 100 then insert 300:
//    - LOOKUP_TOUCH=1 -> evicts 101;
//    - LOOKUP_TOUCH=0 -> evicts 100.
//  - Back-to-back ops with no idle cycles:
//    - insert 5, insert 5, invalidate 5, lookup 5 -> hit_o = 0,1,1,0;
//    - resp_valid_o stays high for 4 consecutive cycles.

Source files
------------

// File: rtl/buffer_lru_pkg.sv
// Shared types for the LRU value buffer family.
package buffer_lru_pkg;

    // Operation codes; encoding 3 is reserved and behaves as an accepted no-op.
    typedef enum logic [1:0] {
        OP_INSERT     = 2'd0,
        OP_LOOKUP     = 2'd1,
        OP_INVALIDATE = 2'd2
    } op_e;

endpackage

// File: rtl/lru_rank_tracker.sv
// True-LRU recency tracker: one rank per slot, 0 = most recent,
// BUF_SIZE-1 = least recent. Ranks always form a permutation.
module lru_rank_tracker #(
    parameter  int BUF_SIZE = 8,
    localparam int IDXW     = $clog2(BUF_SIZE)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            touch_en,
    input  logic [IDXW-1:0] touch_idx,
    input  logic            drop_en,
    input  logic [IDXW-1:0] drop_idx,
    output logic [IDXW-1:0] lru_idx
);

    localparam logic [IDXW-1:0] RANK_LRU = IDXW'(BUF_SIZE - 1);

    logic [IDXW-1:0] rank_r [BUF_SIZE];

    // Rank update: touch promotes a slot to MRU, drop demotes it to LRU;
    // the slots it passes shift by one so the permutation is preserved.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_SIZE; i++) begin
                rank_r[i] <= IDXW'(i);
            end
        end else if (touch_en) begin
            for (int i = 0; i < BUF_SIZE; i++) begin
                if (IDXW'(i) == touch_idx) begin
                    rank_r[i] <= '0;
                end else if (rank_r[i] < rank_r[touch_idx]) begin
                    rank_r[i] <= rank_r[i] + IDXW'(1);
                end
            end
        end else if (drop_en) begin
            for (int i = 0; i < BUF_SIZE; i++) begin
                if (IDXW'(i) == drop_idx) begin
                    rank_r[i] <= RANK_LRU;
                end else if (rank_r[i] > rank_r[drop_idx]) begin
                    rank_r[i] <= rank_r[i] - IDXW'(1);
                end
            end
        end
    end

    // Locate the slot currently holding the LRU rank (exactly one does).
    always_comb begin
        lru_idx = '0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            lru_idx = lru_idx | ((rank_r[i] == RANK_LRU) ? IDXW'(i) : {IDXW{1'b0}});
        end
    end

endmodule

// File: rtl/buffer_lru_cam.sv
// Fully associative value buffer with true-LRU replacement. Owns slot data,
// valid bits, parallel match, victim selection and registered responses;
// recency lives in lru_rank_tracker.
module buffer_lru_cam
    import buffer_lru_pkg::*;
#(
    parameter  int WIDTH        = 16,
    parameter  int BUF_SIZE     = 8,
    parameter  int LOOKUP_TOUCH = 1,
    localparam int IDXW         = $clog2(BUF_SIZE)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            op_valid_i,
    input  op_e                             op_i,
    input  logic [WIDTH-1:0]                val_i,
    output logic                            resp_valid_o,
    output logic                            hit_o,
    output logic [IDXW-1:0]                 slot_o,
    output logic                            evict_valid_o,
    output logic [WIDTH-1:0]                evict_val_o,
    output logic [BUF_SIZE-1:0][WIDTH-1:0]  buf_array_o,
    output logic [BUF_SIZE-1:0]             valid_o,
    output logic [IDXW:0]                   count_o
);

    logic [BUF_SIZE-1:0][WIDTH-1:0] data_r;
    logic [BUF_SIZE-1:0]            valid_r;
    logic [IDXW:0]                  count_r;

    logic                           resp_valid_r;
    logic                           hit_r;
    logic [IDXW-1:0]                slot_r;
    logic                           evict_valid_r;
    logic [WIDTH-1:0]               evict_val_r;

    logic [BUF_SIZE-1:0]            match_s;
    logic                           hit_s;
    logic [IDXW-1:0]                hit_idx_s;
    logic [IDXW-1:0]                free_idx_s;
    logic                           full_s;
    logic [IDXW-1:0]                lru_idx_s;

    logic                           touch_en_s;
    logic [IDXW-1:0]                touch_idx_s;
    logic                           drop_en_s;
    logic [IDXW-1:0]                drop_idx_s;
    logic                           wr_en_s;
    logic [IDXW-1:0]                wr_idx_s;
    logic                           clr_en_s;
    logic                           cnt_inc_s;
    logic                           cnt_dec_s;
    logic                           rsp_hit_s;
    logic [IDXW-1:0]                rsp_slot_s;
    logic                           rsp_ev_s;
    logic [WIDTH-1:0]               rsp_evval_s;

    lru_rank_tracker #(
        .BUF_SIZE (BUF_SIZE)
    ) u_rank (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .touch_en  (touch_en_s),
        .touch_idx (touch_idx_s),
        .drop_en   (drop_en_s),
        .drop_idx  (drop_idx_s),
        .lru_idx   (lru_idx_s)
    );

    // Parallel compare against valid slots; duplicates never exist, so the
    // match vector is at most one-hot and OR-encoding gives the index.
    always_comb begin
        match_s   = '0;
        hit_idx_s = '0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            match_s[i] = valid_r[i] && (data_r[i] == val_i);
            hit_idx_s  = hit_idx_s | (match_s[i] ? IDXW'(i) : {IDXW{1'b0}});
        end
        hit_s = |match_s;
    end

    // Lowest-index invalid slot is the preferred insert target.
    always_comb begin
        free_idx_s = '0;
        for (int i = BUF_SIZE - 1; i >= 0; i--) begin
            free_idx_s = valid_r[i] ? free_idx_s : IDXW'(i);
        end
        full_s = &valid_r;
    end

    // Operation decode: derive state-update strobes and response fields.
    always_comb begin
        touch_en_s  = 1'b0;
        touch_idx_s = '0;
        drop_en_s   = 1'b0;
        drop_idx_s  = '0;
        wr_en_s     = 1'b0;
        wr_idx_s    = '0;
        clr_en_s    = 1'b0;
        cnt_inc_s   = 1'b0;
        cnt_dec_s   = 1'b0;
        rsp_hit_s   = 1'b0;
        rsp_slot_s  = '0;
        rsp_ev_s    = 1'b0;
        rsp_evval_s = '0;
        if (op_valid_i) begin
            case (op_i)
                OP_INSERT: begin
                    if (hit_s) begin
                        rsp_hit_s   = 1'b1;
                        rsp_slot_s  = hit_idx_s;
                        touch_en_s  = 1'b1;
                        touch_idx_s = hit_idx_s;
                    end else if (!full_s) begin
                        wr_en_s     = 1'b1;
                        wr_idx_s    = free_idx_s;
                        cnt_inc_s   = 1'b1;
                        touch_en_s  = 1'b1;
                        touch_idx_s = free_idx_s;
                        rsp_slot_s  = free_idx_s;
                    end else begin
                        wr_en_s     = 1'b1;
                        wr_idx_s    = lru_idx_s;
                        touch_en_s  = 1'b1;
                        touch_idx_s = lru_idx_s;
                        rsp_slot_s  = lru_idx_s;
                        rsp_ev_s    = 1'b1;
                        rsp_evval_s = data_r[lru_idx_s];
                    end
                end
                OP_LOOKUP: begin
                    if (hit_s) begin
                        rsp_hit_s   = 1'b1;
                        rsp_slot_s  = hit_idx_s;
                        touch_en_s  = (LOOKUP_TOUCH != 0);
                        touch_idx_s = hit_idx_s;
                    end else begin
                        rsp_hit_s   = 1'b0;
                    end
                end
                OP_INVALIDATE: begin
                    if (hit_s) begin
                        rsp_hit_s   = 1'b1;
                        rsp_slot_s  = hit_idx_s;
                        drop_en_s   = 1'b1;
                        drop_idx_s  = hit_idx_s;
                        clr_en_s    = 1'b1;
                        cnt_dec_s   = 1'b1;
                    end else begin
                        rsp_hit_s   = 1'b0;
                    end
                end
                default: begin
                    rsp_hit_s = 1'b0;
                end
            endcase
        end else begin
            rsp_hit_s = 1'b0;
        end
    end

    // Slot contents, valid mask and occupancy count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_r  <= '0;
            valid_r <= '0;
            count_r <= '0;
        end else begin
            if (wr_en_s) begin
                data_r[wr_idx_s]  <= val_i;
                valid_r[wr_idx_s] <= 1'b1;
            end
            if (clr_en_s) begin
                data_r[drop_idx_s]  <= '0;
                valid_r[drop_idx_s] <= 1'b0;
            end
            if (cnt_inc_s) begin
                count_r <= count_r + (IDXW+1)'(1);
            end else if (cnt_dec_s) begin
                count_r <= count_r - (IDXW+1)'(1);
            end
        end
    end

    // Response registers: one-cycle pulse after each accepted op.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_r  <= 1'b0;
            hit_r         <= 1'b0;
            slot_r        <= '0;
            evict_valid_r <= 1'b0;
            evict_val_r   <= '0;
        end else begin
            resp_valid_r  <= op_valid_i;
            hit_r         <= rsp_hit_s;
            slot_r        <= rsp_slot_s;
            evict_valid_r <= rsp_ev_s;
            evict_val_r   <= rsp_evval_s;
        end
    end

    assign resp_valid_o  = resp_valid_r;
    assign hit_o         = hit_r;
    assign slot_o        = slot_r;
    assign evict_valid_o = evict_valid_r;
    assign evict_val_o   = evict_val_r;
    assign buf_array_o   = data_r;
    assign valid_o       = valid_r;
    assign count_o       = count_r;

endmodule

// File: tb/tb_buffer_lru_cam.sv
// Bench for buffer_lru_cam: two instances (LOOKUP_TOUCH=1 and 0) share the
// stimulus; a recency-list model predicts every output of both each cycle.
module tb_buffer_lru_cam;
    import buffer_lru_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic        op_valid;
    op_e         op_s;
    logic [15:0] val_s;

    logic [1:0]            rv_w, hit_w, ev_w;
    logic [1:0][2:0]       slot_w;
    logic [1:0][15:0]      evv_w;
    logic [1:0][7:0][15:0] arr_w;
    logic [1:0][7:0]       vld_w;
    logic [1:0][3:0]       cnt_w;

    buffer_lru_cam #(.WIDTH(16), .BUF_SIZE(8), .LOOKUP_TOUCH(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .op_valid_i(op_valid), .op_i(op_s), .val_i(val_s),
        .resp_valid_o(rv_w[0]), .hit_o(hit_w[0]), .slot_o(slot_w[0]),
        .evict_valid_o(ev_w[0]), .evict_val_o(evv_w[0]), .buf_array_o(arr_w[0]),
        .valid_o(vld_w[0]), .count_o(cnt_w[0]));

    buffer_lru_cam #(.WIDTH(16), .BUF_SIZE(8), .LOOKUP_TOUCH(0)) dut_nt (
        .clk_i(clk), .rst_i(rst_i), .op_valid_i(op_valid), .op_i(op_s), .val_i(val_s),
        .resp_valid_o(rv_w[1]), .hit_o(hit_w[1]), .slot_o(slot_w[1]),
        .evict_valid_o(ev_w[1]), .evict_val_o(evv_w[1]), .buf_array_o(arr_w[1]),
        .valid_o(vld_w[1]), .count_o(cnt_w[1]));

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    // Model: contents, valid flags, and a recency list (ord[k][0] = MRU slot).
    int unsigned mdata [2][N];
    bit          mvalid[2][N];
    int          ord   [2][N];
    bit          exp_rv[2], exp_hit[2], exp_ev[2];
    int          exp_slot[2];
    int unsigned exp_evv[2];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                mdata[k][i] = 0; mvalid[k][i] = 1'b0; ord[k][i] = i;
            end
            exp_rv[k] = 1'b0; exp_hit[k] = 1'b0; exp_slot[k] = 0;
            exp_ev[k] = 1'b0; exp_evv[k] = 0;
        end
    endtask

    task automatic touch(input int k, input int s);
        int p = 0;
        for (int q = 0; q < N; q++) if (ord[k][q] == s) p = q;
        for (int q = p; q > 0; q--) ord[k][q] = ord[k][q-1];
        ord[k][0] = s;
    endtask

    task automatic drop(input int k, input int s);
        int p = 0;
        for (int q = 0; q < N; q++) if (ord[k][q] == s) p = q;
        for (int q = p; q < N - 1; q++) ord[k][q] = ord[k][q+1];
        ord[k][N-1] = s;
    endtask

    task automatic model_op(input int k, input bit v, input int op, input int unsigned val, input bit lt);
        int h = -1;
        int fr = -1;
        int s;
        exp_rv[k] = v; exp_hit[k] = 1'b0; exp_slot[k] = 0; exp_ev[k] = 1'b0; exp_evv[k] = 0;
        if (v) begin
            for (int i = 0; i < N; i++) if (mvalid[k][i] && mdata[k][i] == val) h = i;
            for (int i = N - 1; i >= 0; i--) if (!mvalid[k][i]) fr = i;
            case (op)
                0: begin
                    if (h >= 0) begin
                        exp_hit[k] = 1'b1; exp_slot[k] = h; touch(k, h);
                    end else begin
                        s = (fr >= 0) ? fr : ord[k][N-1];
                        if (fr < 0) begin exp_ev[k] = 1'b1; exp_evv[k] = mdata[k][s]; end
                        mdata[k][s] = val; mvalid[k][s] = 1'b1; exp_slot[k] = s; touch(k, s);
                    end
                end
                1: if (h >= 0) begin
                    exp_hit[k] = 1'b1; exp_slot[k] = h;
                    if (lt) touch(k, h);
                end
                2: if (h >= 0) begin
                    exp_hit[k] = 1'b1; exp_slot[k] = h;
                    mvalid[k][h] = 1'b0; mdata[k][h] = 0; drop(k, h);
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle's request at the falling edge and advance the model.
    task automatic step(input bit v, input int op, input int unsigned val);
        @(negedge clk);
        op_valid = v;
        op_s     = op_e'(op[1:0]);
        val_s    = val[15:0];
        model_op(0, v, op, {16'd0, val[15:0]}, 1'b1);
        model_op(1, v, op, {16'd0, val[15:0]}, 1'b0);
    endtask

    task automatic op_chk(input int op, input int unsigned val);
        step(1'b1, op, val);
        @(posedge clk);
        #2;
    endtask

    task automatic fill_100();
        for (int v = 100; v < 108; v++) step(1'b1, 0, v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst.count", cnt_w[0], 128'd0);
        check("rst.valid", vld_w[0], 128'd0);
        model_reset();
        op_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_i = 1'b0;
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [7:0][15:0] ea;
                logic [7:0]       ev;
                int               ec;
                ec = 0;
                for (int i = 0; i < N; i++) begin
                    ea[i] = mdata[k][i][15:0];
                    ev[i] = mvalid[k][i];
                    ec += int'(mvalid[k][i]);
                end
                check($sformatf("u%0d.resp_valid", k), rv_w[k], exp_rv[k]);
                if (exp_rv[k]) begin
                    check($sformatf("u%0d.hit", k), hit_w[k], exp_hit[k]);
                    check($sformatf("u%0d.slot", k), slot_w[k], exp_slot[k]);
                    check($sformatf("u%0d.evict_valid", k), ev_w[k], exp_ev[k]);
                end
                check($sformatf("u%0d.evict_val", k), evv_w[k], exp_evv[k]);
                check($sformatf("u%0d.array", k), arr_w[k], ea);
                check($sformatf("u%0d.valid", k), vld_w[k], ev);
                check($sformatf("u%0d.count", k), cnt_w[k], ec);
            end
        end
    end

    initial begin
        int               seq[15];
        logic [7:0][15:0] fa;
        rst_i = 1'b1; op_valid = 1'b0; op_s = OP_INSERT; val_s = 16'd0;
        model_reset();
        @(posedge clk);
        #3;
        check("init.resp_valid", rv_w[0], 128'd0);
        check("init.count", cnt_w[0], 128'd0);
        check("init.array", arr_w[0], 128'd0);
        chk_en = 1'b1;
        rst_i  = 1'b0;

        // Fill and LRU replacement
        seq = '{100, 101, 102, 103, 101, 104, 105, 106, 107, 108, 109, 110, 110, 111, 112};
        for (int j = 0; j < 15; j++) begin
            op_chk(0, seq[j]);
            if (j == 4)  check("lru.hit101", hit_w[0], 128'd1);
            if (j == 9) begin
                check("lru.ev108", ev_w[0], 128'd1);
                check("lru.evval108", evv_w[0], 128'd100);
                check("lru.slot108", slot_w[0], 128'd0);
            end
            if (j == 11) check("lru.miss110", hit_w[0], 128'd0);
            if (j == 12) check("lru.hit110", hit_w[0], 128'd1);
        end
        fa[0] = 16'd108; fa[1] = 16'd111; fa[2] = 16'd109; fa[3] = 16'd110;
        fa[4] = 16'd112; fa[5] = 16'd105; fa[6] = 16'd106; fa[7] = 16'd107;
        check("lru.array_t1", arr_w[0], fa);
        check("lru.array_t0", arr_w[1], fa);
        step(1'b0, 0, 0);
        do_reset();

        // Value zero is storable
        op_chk(0, 0);
        check("zero.valid", vld_w[0], 128'h01);
        check("zero.count", cnt_w[0], 128'd1);
        op_chk(1, 0);
        check("zero.hit", hit_w[0], 128'd1);
        check("zero.slot", slot_w[0], 128'd0);
        step(1'b0, 0, 0);
        do_reset();

        // Invalidate and refill
        fill_100();
        op_chk(2, 103);
        check("inv.valid", vld_w[0], 128'hF7);
        check("inv.count", cnt_w[0], 128'd7);
        op_chk(0, 200);
        check("inv.slot200", slot_w[0], 128'd3);
        check("inv.ev200", ev_w[0], 128'd0);
        op_chk(0, 201);
        check("inv.ev201", ev_w[0], 128'd1);
        check("inv.evval201", evv_w[0], 128'd100);
        step(1'b0, 0, 0);
        do_reset();

        // Lookup recency refresh on vs off
        fill_100();
        op_chk(1, 100);
        op_chk(0, 300);
        check("lt1.evval", evv_w[0], 128'd101);
        check("lt0.evval", evv_w[1], 128'd100);
        step(1'b0, 0, 0);
        do_reset();

        // Back-to-back ops
        op_chk(0, 5);
        check("b2b.hit0", hit_w[0], 128'd0); check("b2b.rv0", rv_w[0], 128'd1);
        op_chk(0, 5);
        check("b2b.hit1", hit_w[0], 128'd1); check("b2b.rv1", rv_w[0], 128'd1);
        op_chk(2, 5);
        check("b2b.hit2", hit_w[0], 128'd1); check("b2b.rv2", rv_w[0], 128'd1);
        op_chk(1, 5);
        check("b2b.hit3", hit_w[0], 128'd0); check("b2b.rv3", rv_w[0], 128'd1);
        step(1'b0, 0, 0);
        @(posedge clk);
        #2;
        check("b2b.rv_idle", rv_w[0], 128'd0);

        // Asynchronous reset in the middle of an op
        step(1'b1, 0, 50);
        step(1'b1, 0, 77);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst.resp_valid", rv_w[0], 128'd0);
        check("arst.count", cnt_w[0], 128'd0);
        check("arst.valid", vld_w[0], 128'd0);
        check("arst.array", arr_w[0], 128'd0);
        model_reset();
        step(1'b0, 0, 0);
        @(posedge clk);
        #3;
        rst_i = 1'b0;
        step(1'b0, 0, 0);
        @(posedge clk);
        #2;
        check("arst.no_resp", rv_w[0], 128'd0);

        // Randomized traffic
        repeat (1500) begin
            bit          v;
            int          op;
            int unsigned val;
            v   = ($urandom_range(0, 9) < 8);
            op  = $urandom_range(0, 3);
            val = $urandom_range(0, 12);
            if ($urandom_range(0, 15) == 0) val = $urandom & 32'h0000_FFFF;
            step(v, op, val);
        end
        step(1'b0, 0, 0);
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
